// File: rtl/pmod_jstk_responder.sv
// SPI mode-0 responder emulating a PmodJSTK: returns a 5-byte position/button
// frame on miso and latches LED command bits from the first mosi byte.
module pmod_jstk_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led_cmd,
  output logic       xfer_done,
  output logic       xfer_abort,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_prev_q, sclk_prev_q;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] frame_q, frame_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        miso_q, miso_d;
  logic [1:0]  led_q, led_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;

  logic        ss_s, sclk_s, mosi_s;
  logic        ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;
  logic [39:0] snap_s;

  // Synchronizer shift chains (SYNC_STAGES must be at least 2)
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall_s   = ss_prev_q & ~ss_s;
  assign ss_rise_s   = ~ss_prev_q & ss_s;
  assign sclk_rise_s = ~sclk_prev_q & sclk_s;
  assign sclk_fall_s = sclk_prev_q & ~sclk_s;
  assign snap_s      = {x_pos[7:0], 6'b000000, x_pos[9:8],
                        y_pos[7:0], 6'b000000, y_pos[9:8],
                        5'b00000, buttons};

  // Transaction sequencer; an ss rise pre-empts any sclk edge in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    cmd_d   = cmd_q;
    miso_d  = miso_q;
    led_d   = led_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_s) begin
          state_d = ST_SHIFT;
          frame_d = snap_s;
          cnt_d   = 6'd0;
          cmd_d   = 8'h00;
          miso_d  = snap_s[39];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          miso_d  = 1'b0;
          cnt_d   = 6'd0;
        end else if (sclk_rise_s) begin
          cmd_d = {cmd_q[6:0], mosi_s};
          cnt_d = cnt_q + 6'd1;
          if ((cnt_d == 6'd8) && cmd_d[7]) begin
            led_d = cmd_d[1:0];
          end else begin
            led_d = led_q;
          end
          if (cnt_d == 6'd40) begin
            state_d = ST_DRAIN;
            miso_d  = 1'b0;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (sclk_fall_s) begin
          frame_d = {frame_q[38:0], 1'b0};
          miso_d  = frame_d[39];
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        miso_d = 1'b0;
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
        miso_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      frame_q     <= 40'd0;
      cmd_q       <= 8'h00;
      miso_q      <= 1'b0;
      led_q       <= 2'b00;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      cmd_q       <= cmd_d;
      miso_q      <= miso_d;
      led_q       <= led_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign miso       = miso_q;
  assign led_cmd    = led_q;
  assign xfer_done  = done_q;
  assign xfer_abort = abort_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Scoreboard bench: an SPI initiator drives directed and random transactions,
// monitors compare miso bits and completion pulses against a reference model.
module tb_pmod_jstk_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] x_pos = 10'd0;
  logic [9:0] y_pos = 10'd0;
  logic [2:0] buttons = 3'd0;
  logic [1:0] led_cmd;
  logic       xfer_done;
  logic       xfer_abort;
  logic       busy;

  typedef struct packed {
    logic       is_done;
    logic [1:0] led;
  } ev_t;

  ev_t  ev_q[$];
  logic bit_q[$];
  logic [1:0] led_model = 2'b00;
  int total = 0;
  int bad = 0;

  pmod_jstk_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .led_cmd(led_cmd),
    .xfer_done(xfer_done), .xfer_abort(xfer_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The five bytes a joystick would return, built from position and buttons
  function automatic logic [39:0] model_frame(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b);
    logic [7:0] bytes [5];
    bytes[0] = 8'(x % 256);
    bytes[1] = 8'(x / 256);
    bytes[2] = 8'(y % 256);
    bytes[3] = 8'(y / 256);
    bytes[4] = 8'(b);
    return {bytes[0], bytes[1], bytes[2], bytes[3], bytes[4]};
  endfunction

  // Monitor: initiator samples miso on each sclk rise
  always @(posedge sclk) begin
    if (bit_q.size() == 0) begin
      check("miso_extra_bit", 32'(1), 32'(0));
    end else begin
      check("miso_bit", 32'(miso), 32'(bit_q.pop_front()));
    end
  end

  // Monitor: completion pulses
  always @(negedge clk) begin
    if (rst && (xfer_done || xfer_abort)) begin
      if (ev_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, xfer_done, xfer_abort}, 32'(0));
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        check("pulse_kind", {30'd0, xfer_done, xfer_abort},
              e.is_done ? 32'(2) : 32'(1));
        check("led_cmd", 32'(led_cmd), 32'(e.led));
        check("busy_at_end", 32'(busy), 32'(0));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_miso", 32'(miso), 32'(0));
    check("rst_led", 32'(led_cmd), 32'(0));
    check("rst_done", 32'(xfer_done), 32'(0));
    check("rst_abort", 32'(xfer_abort), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
  endtask

  task automatic randomize_inputs();
    logic [31:0] r;
    r = $urandom;
    x_pos = r[9:0];
    y_pos = r[19:10];
    buttons = r[22:20];
  endtask

  // mutate: 0 none, 1 random inputs, 2 x_pos cleared after ss falls
  task automatic xfer(input int nbits, input logic [47:0] mw, input int mutate, input int rst_at);
    logic [39:0] fr;
    int nchk;
    fr = model_frame(x_pos, y_pos, buttons);
    nchk = (rst_at >= 0 && rst_at < nbits) ? rst_at : nbits;
    for (int i = 0; i < nchk; i++) bit_q.push_back(i < 40 ? fr[39-i] : 1'b0);
    if (!(rst_at >= 0 && rst_at < nbits)) begin
      if (nbits >= 8 && mw[47]) led_model = mw[41:40];
      ev_q.push_back('{is_done: (nbits >= 40), led: led_model});
    end
    ss = 1'b0;
    #160;
    if (mutate == 1) randomize_inputs();
    else if (mutate == 2) x_pos = 10'h000;
    for (int i = 0; i < nbits; i++) begin
      mosi = mw[47-i];
      #80;
      if (i == rst_at) begin
        rst = 1'b0;
        #30;
        check_reset_outputs();
        ss = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        #30;
        rst = 1'b1;
        led_model = 2'b00;
        #100;
        return;
      end
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
    #80;
    ss = 1'b1;
    #200;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #30;
    check_reset_outputs();
    #20;
    rst = 1'b1;
    #100;
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_miso", 32'(miso), 32'(0));

    x_pos = 10'h2A5; y_pos = 10'h1FF; buttons = 3'b101;
    xfer(40, {8'h03, 40'd0}, 0, -1);
    xfer(40, {8'h83, 40'hF0F0F0F0F0}, 0, -1);
    xfer(12, {8'h81, 40'hA000000000}, 0, -1);
    x_pos = 10'h2A5;
    xfer(40, {8'h82, 40'd0}, 2, -1);
    x_pos = 10'h133; y_pos = 10'h2CC;
    xfer(40, {8'h83, 40'd0}, 0, 20);
    xfer(40, {8'h82, 40'd0}, 0, -1);
    xfer(48, {8'h81, 40'hFFFFFFFFFF}, 0, -1);
    xfer(0, 48'd0, 0, -1);
    xfer(7, {8'h80, 40'd0}, 0, -1);
    for (int k = 0; k < 8; k++) begin
      int nb;
      logic [31:0] a, b;
      randomize_inputs();
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : int'($urandom_range(40, 48));
      a = $urandom;
      b = $urandom;
      xfer(nb, {a[15:0], b}, 1, -1);
    end
    #500;
    check("events_left", 32'(ev_q.size()), 32'(0));
    check("bits_left", 32'(bit_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
